// File: rtl/line_backing_mem_pkg.sv
// Shared types and size helpers for the data-side line backing memory.
package line_backing_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  function automatic int unsigned bytes_per_word(int unsigned word_w);
    return word_w / 8;
  endfunction

  function automatic int unsigned line_bytes(int unsigned word_w, int unsigned line_words);
    return (line_words * word_w) / 8;
  endfunction

  function automatic int unsigned word_ofs_w(int unsigned word_w);
    return $clog2(word_w / 8);
  endfunction

  function automatic int unsigned line_ofs_w(int unsigned word_w, int unsigned line_words);
    return $clog2(line_bytes(word_w, line_words));
  endfunction

  // Counter must reach max(RD_LAT,WR_LAT)-1; never narrower than one bit.
  function automatic int unsigned cnt_w(int unsigned rd_lat, int unsigned wr_lat);
    int unsigned m;
    m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/line_backing_mem_lat_counter.sv
// Load/enable latency counter with terminal-count flag; shared with the
// instruction-side backing memory.
module mem_lat_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] count;

  // Clear on load, otherwise count up while enabled.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == tc_val);

endmodule

// File: rtl/line_backing_mem.sv
// Byte-addressed backing memory: whole-line reads, byte-masked word writes,
// separate programmable read/write latency, one-cycle ready pulse.
// Optional: LINE_BACKING_MEM_MISALIGN_ERR_EN adds an err output and
// suppresses misaligned accesses instead of silently aligning them.
module line_backing_mem
  import line_backing_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned RD_LAT     = 4,
  parameter int unsigned WR_LAT     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rd_req,
  input  logic                         wr_req,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [WORD_W-1:0]            wdata,
  input  logic [WORD_W/8-1:0]          wstrb,
  output logic [LINE_WORDS*WORD_W-1:0] rdata,
  output logic                         ready,
  output logic                         busy
`ifdef LINE_BACKING_MEM_MISALIGN_ERR_EN
  ,
  output logic                         err
`endif
);

  localparam int unsigned BPW        = bytes_per_word(WORD_W);
  localparam int unsigned LB         = line_bytes(WORD_W, LINE_WORDS);
  localparam int unsigned WORD_OFS_W = word_ofs_w(WORD_W);
  localparam int unsigned LINE_OFS_W = line_ofs_w(WORD_W, LINE_WORDS);
  localparam int unsigned CNT_W      = cnt_w(RD_LAT, WR_LAT);

  localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'((1 << WORD_OFS_W) - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << LINE_OFS_W) - 1);
  localparam logic [CNT_W-1:0]  RD_TC     = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  WR_TC     = CNT_W'(WR_LAT - 1);

  logic [7:0] mem [2**ADDR_W];

  state_t              state, next_state;
  op_t                 lat_op;
  logic [ADDR_W-1:0]   lat_addr;
  logic [WORD_W-1:0]   lat_wdata;
  logic [BPW-1:0]      lat_wstrb;
  logic                accept_wr, accept_rd, commit, cnt_en, cnt_tc;
  logic [CNT_W-1:0]    tc_val;
  logic [ADDR_W-1:0]   word_base, line_base;
  logic                misaligned;

  assign word_base = lat_addr & ~WORD_MASK;
  assign line_base = lat_addr & ~LINE_MASK;
  assign tc_val    = (lat_op == OP_WR) ? WR_TC : RD_TC;

`ifdef LINE_BACKING_MEM_MISALIGN_ERR_EN
  assign misaligned = (lat_op == OP_WR) ? |(lat_addr & WORD_MASK) : |(lat_addr & LINE_MASK);
`else
  assign misaligned = 1'b0;
`endif

  mem_lat_counter #(.W(CNT_W)) u_lat_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (accept_wr | accept_rd),
    .en     (cnt_en),
    .tc_val (tc_val),
    .tc     (cnt_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and per-cycle control; requests only sampled in IDLE, write wins.
  always_comb begin
    next_state = state;
    accept_wr  = 1'b0;
    accept_rd  = 1'b0;
    commit     = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          accept_wr  = 1'b1;
          next_state = WAIT;
        end else if (rd_req) begin
          accept_rd  = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          commit     = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch, handshake outputs and read line capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready     <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      lat_op    <= OP_RD;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
`ifdef LINE_BACKING_MEM_MISALIGN_ERR_EN
      err       <= 1'b0;
`endif
    end else begin
      ready <= commit;
`ifdef LINE_BACKING_MEM_MISALIGN_ERR_EN
      err   <= commit & misaligned;
`endif
      if (accept_wr || accept_rd) begin
        busy     <= 1'b1;
        lat_addr <= addr;
        lat_op   <= accept_wr ? OP_WR : OP_RD;
      end
      if (accept_wr) begin
        lat_wdata <= wdata;
        lat_wstrb <= wstrb;
      end
      if (state == DONE) begin
        busy <= 1'b0;
      end
      if (commit && (lat_op == OP_RD) && !misaligned) begin
        for (int unsigned k = 0; k < LB; k++) begin
          rdata[8*k +: 8] <= mem[line_base + ADDR_W'(k)];
        end
      end
    end
  end

  // Array write on the commit cycle; a reset on that edge abandons the write.
  always_ff @(posedge clk) begin
    if (!reset && commit && (lat_op == OP_WR) && !misaligned) begin
      for (int unsigned i = 0; i < BPW; i++) begin
        if (lat_wstrb[i]) begin
          mem[word_base + ADDR_W'(i)] <= lat_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_line_backing_mem.sv
// Scoreboard bench for line_backing_mem with a byte-array reference model.
// Honours LINE_BACKING_MEM_MISALIGN_ERR_EN when defined.
module tb_line_backing_mem;

  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned RD_LAT     = 1;
  localparam int unsigned WR_LAT     = 4;
  localparam int unsigned LW         = LINE_WORDS * WORD_W;
  localparam int unsigned SW         = WORD_W / 8;
  localparam int unsigned LB         = LW / 8;
  localparam int unsigned MEMSZ      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rd_req = 1'b0;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [WORD_W-1:0] wdata = '0;
  logic [SW-1:0]     wstrb = '0;
  logic [LW-1:0]     rdata;
  logic              ready;
  logic              busy;
`ifdef LINE_BACKING_MEM_MISALIGN_ERR_EN
  logic              err;
`endif

  always #5 clk = ~clk;

  line_backing_mem #(
    .ADDR_W     (ADDR_W),
    .WORD_W     (WORD_W),
    .LINE_WORDS (LINE_WORDS),
    .RD_LAT     (RD_LAT),
    .WR_LAT     (WR_LAT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rd_req (rd_req),
    .wr_req (wr_req),
    .addr   (addr),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .rdata  (rdata),
    .ready  (ready),
    .busy   (busy)
`ifdef LINE_BACKING_MEM_MISALIGN_ERR_EN
    ,
    .err    (err)
`endif
  );

  typedef struct {
    bit            is_rd;
    longint        edge_n;
    logic [LW-1:0] line;
    bit            err;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [7:0]    ref_mem [MEMSZ];
  logic [LW-1:0] last_line = '0;
  longint        cyc = 0;
  longint        free_edge = 0;
  int            compared = 0;
  int            mismatched = 0;
  int            ready_count = 0;
  int            busy_run = 0;
  int            last_busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_misaligned(input bit is_rd, input logic [ADDR_W-1:0] a);
`ifdef LINE_BACKING_MEM_MISALIGN_ERR_EN
    return is_rd ? ((int'(a) % LB) != 0) : ((int'(a) % SW) != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_write(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d, input logic [SW-1:0] s);
    int base;
    base = int'(a) - (int'(a) % SW);
    for (int i = 0; i < SW; i++) if (s[i]) ref_mem[base + i] = d[8*i +: 8];
  endtask

  function automatic logic [LW-1:0] model_line(input logic [ADDR_W-1:0] a);
    logic [LW-1:0] l;
    int base;
    base = int'(a) - (int'(a) % LB);
    for (int k = 0; k < LB; k++) l[8*k +: 8] = ref_mem[base + k];
    return l;
  endfunction

  // Monitor: every ready pulse pops one expectation.
  always @(negedge clk) begin
    if (!reset && ready) begin
      ready_count++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_ready: got ready at edge %0d, expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("ready_edge", LW'(cyc), LW'(mon_e.edge_n));
        if (mon_e.is_rd) check("rdata", rdata, mon_e.line);
`ifdef LINE_BACKING_MEM_MISALIGN_ERR_EN
        check("err", LW'(err), LW'(mon_e.err));
`endif
      end
    end
  end

  // Busy run-length tracker.
  always @(negedge clk) begin
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (ready_count >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL ready_timeout: got %0d ready pulses, expected %0d", ready_count, target);
      sb.delete();
    end
  endtask

  task automatic access(input bit is_rd, input bit both, input logic [ADDR_W-1:0] a,
                        input logic [WORD_W-1:0] d, input logic [SW-1:0] s, input bit scramble);
    longint acc, acc_first;
    exp_t   e;
    int     base_cnt;
    bit     ok;
    acc = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
    acc_first = acc;
    if (!is_rd || both) begin
      e.is_rd = 1'b0;
      e.edge_n = acc + WR_LAT;
      e.line = '0;
      e.err = is_misaligned(1'b0, a);
      if (!e.err) model_write(a, d, s);
      sb.push_back(e);
      free_edge = acc + WR_LAT + 2;
      acc = free_edge;
    end
    if (is_rd || both) begin
      e.is_rd = 1'b1;
      e.edge_n = acc + RD_LAT;
      e.err = is_misaligned(1'b1, a);
      if (!e.err) last_line = model_line(a);
      e.line = last_line;
      sb.push_back(e);
      free_edge = acc + RD_LAT + 2;
    end
    base_cnt = ready_count;
    addr = a;
    wdata = d;
    wstrb = s;
    wr_req = !is_rd || both;
    rd_req = is_rd || both;
    if (scramble) begin
      for (int i = 0; i < 64 && cyc < acc_first; i++) tick();
      addr = ADDR_W'($urandom);
      wdata = $urandom;
      wstrb = SW'($urandom);
    end
    wait_ready(base_cnt + 1, ok);
    wr_req = 1'b0;
    if (both && ok) wait_ready(base_cnt + 2, ok);
    rd_req = 1'b0;
    tick();
    if (!both && ok) check("busy_cycles", LW'(last_busy_run), LW'((is_rd ? RD_LAT : WR_LAT) + 1));
    if (both && ok) check("two_readys", LW'(ready_count - base_cnt), LW'(2));
  endtask

  task automatic reset_mid_write(input logic [ADDR_W-1:0] a);
    longint acc;
    acc = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
    addr = a;
    wdata = $urandom;
    wstrb = '1;
    wr_req = 1'b1;
    for (int i = 0; i < 64 && cyc < acc + 2; i++) tick();
    reset = 1'b1;
    wr_req = 1'b0;
    tick();
    check("rst_mid_ready", LW'(ready), '0);
    check("rst_mid_busy", LW'(busy), '0);
    check("rst_mid_rdata", rdata, '0);
    reset = 1'b0;
    last_line = '0;
    free_edge = cyc + 1;
    repeat (8) tick();
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] a;
    a = ADDR_W'($urandom_range(0, 255));
    if ($urandom_range(0, 1) == 1) a = a + ADDR_W'(MEMSZ - 256);
    return a;
  endfunction

  initial begin
    logic [ADDR_W-1:0] rd2;
    int r;
    reset = 1'b1;
    repeat (3) tick();
    check("reset_ready", LW'(ready), '0);
    check("reset_busy", LW'(busy), '0);
    check("reset_rdata", rdata, '0);
    reset = 1'b0;
    free_edge = cyc + 1;

    for (int w = 0; w < 64; w++) begin
      access(1'b0, 1'b0, ADDR_W'(w * SW), $urandom, '1, 1'b0);
      access(1'b0, 1'b0, ADDR_W'(MEMSZ - 256 + w * SW), $urandom, '1, 1'b0);
    end

    access(1'b0, 1'b0, 12'h004, 32'hDEADBEEF, 4'hF, 1'b0);
    access(1'b1, 1'b0, 12'h000, '0, '0, 1'b0);
    check("line_word1", LW'(rdata[63:32]), LW'(32'hDEADBEEF));

    access(1'b0, 1'b0, 12'h010, 32'h11223344, 4'hF, 1'b0);
    access(1'b0, 1'b0, 12'h010, 32'hAABBCCDD, 4'b0101, 1'b0);
`ifdef LINE_BACKING_MEM_MISALIGN_ERR_EN
    rd2 = 12'h010;
`else
    rd2 = 12'h013;
`endif
    access(1'b1, 1'b0, rd2, '0, '0, 1'b0);
    check("strobe_word0", LW'(rdata[31:0]), LW'(32'h11BB33DD));

    access(1'b1, 1'b1, 12'h020, 32'hCAFEF00D, 4'hF, 1'b0);
    check("rw_both_word0", LW'(rdata[31:0]), LW'(32'hCAFEF00D));

    access(1'b0, 1'b0, 12'h050, 32'h55AA55AA, 4'h0, 1'b1);
    access(1'b1, 1'b0, 12'h050, '0, '0, 1'b1);

    reset_mid_write(12'h030);
    access(1'b1, 1'b0, 12'h030, '0, '0, 1'b0);

`ifdef LINE_BACKING_MEM_MISALIGN_ERR_EN
    access(1'b0, 1'b0, 12'h031, 32'h12345678, 4'hF, 1'b0);
    access(1'b1, 1'b0, 12'h030, '0, '0, 1'b0);
    access(1'b0, 1'b0, 12'h030, 32'h87654321, 4'hF, 1'b0);
`endif

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) access(1'b0, 1'b0, rand_addr(), $urandom, SW'($urandom), 1'($urandom));
      else if (r < 8) access(1'b1, 1'b0, rand_addr(), '0, '0, 1'($urandom));
      else access(1'b1, 1'b1, rand_addr(), $urandom, SW'($urandom), 1'b0);
    end

    repeat (4) tick();
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL pending_expect: got %0d outstanding, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
